// File: rtl/axi_pkg.sv
// Shared AXI4 constants and FSM state types for cache_axi_master and its write path.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  // Any response other than OKAY counts as an error, including EXOKAY.
  function automatic logic resp_err(input logic [1:0] r);
    return (r != OKAY) && (r inside {EXOKAY, SLVERR, DECERR});
  endfunction

endpackage

// File: rtl/cache_axi_master_wr.sv
// Write path of cache_axi_master: AW issue, W beats with a beat counter, then B wait.
module cache_axi_master_wr
  import axi_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int WR_ID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce_i,
  input  logic            wen_i,
  input  logic [31:0]     waddr_i,
  input  logic [7:0]      wlen_i,
  input  logic [3:0]      wsel_i,
  input  logic [31:0]     wdata_i,
  output logic            wdata_resp_o,
  output logic [ID_W-1:0] m_awid,
  output logic [31:0]     m_awaddr,
  output logic [7:0]      m_awlen,
  output logic [2:0]      m_awsize,
  output logic [1:0]      m_awburst,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [31:0]     m_wdata,
  output logic [3:0]      m_wstrb,
  output logic            m_wlast,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  logic            m_bvalid,
  output logic            m_bready,
  output logic [1:0]      wr_state_o
);

  wr_state_t   state, state_nx;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [3:0]  wstrb;
  logic [7:0]  beat_cnt;
  logic        guard;
  logic        start;
  logic        b_done;
  logic        w_hs;

  assign m_awid     = ID_W'(WR_ID);
  assign m_awaddr   = awaddr;
  assign m_awlen    = awlen;
  assign m_awsize   = AXI_SIZE_4B;
  assign m_awburst  = AXI_BURST_INCR;
  assign m_wdata    = wdata_i;
  assign m_wstrb    = wstrb;
  assign m_wlast    = (state == W_DATA) && (beat_cnt == awlen);
  assign w_hs       = m_wvalid & m_wready;
  assign wr_state_o = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= W_IDLE;
      awaddr   <= '0;
      awlen    <= '0;
      wstrb    <= '0;
      beat_cnt <= '0;
      guard    <= 1'b0;
    end else begin
      state <= state_nx;
      guard <= b_done;
      if (start) begin
        awaddr   <= waddr_i;
        awlen    <= wlen_i;
        wstrb    <= wsel_i;
        beat_cnt <= '0;
      end else if (w_hs && !m_wlast) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  // The last W beat does not pulse upstream; that pulse is deferred until B arrives.
  always_comb begin
    state_nx     = state;
    start        = 1'b0;
    b_done       = 1'b0;
    m_awvalid    = 1'b0;
    m_wvalid     = 1'b0;
    m_bready     = 1'b0;
    wdata_resp_o = 1'b0;
    case (state)
      W_IDLE: begin
        if (ce_i && wen_i && !guard) begin
          start    = 1'b1;
          state_nx = W_ADDR;
        end
      end
      W_ADDR: begin
        m_awvalid = 1'b1;
        if (m_awready) state_nx = W_DATA;
      end
      W_DATA: begin
        m_wvalid = 1'b1;
        if (m_wready) begin
          if (m_wlast) state_nx = W_RESP;
          else         wdata_resp_o = 1'b1;
        end
      end
      W_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          wdata_resp_o = 1'b1;
          b_done       = 1'b1;
          state_nx     = W_IDLE;
        end
      end
      default: state_nx = W_IDLE;
    endcase
  end

endmodule

// File: rtl/cache_axi_master.sv
// Bridges the cache arbiter's per-word bus onto AXI4 AR/R/AW/W/B; read and write run independently.
// Optional sticky error capture on R/B responses is enabled by defining AXI_ERR_CAPTURE_EN.
module cache_axi_master
  import axi_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int RD_ID = 0,
  parameter int WR_ID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce_i,
  input  logic            ren_i,
  input  logic [31:0]     raddr_i,
  input  logic [7:0]      rlen_i,
  input  logic            rready_i,
  output logic [31:0]     rdata_o,
  output logic            rdata_valid_o,
  input  logic            wen_i,
  input  logic [31:0]     waddr_i,
  input  logic [7:0]      wlen_i,
  input  logic [3:0]      wsel_i,
  input  logic [31:0]     wdata_i,
  output logic            wdata_resp_o,
`ifdef AXI_ERR_CAPTURE_EN
  output logic            err_o,
  output logic [31:0]     err_addr_o,
`endif
  output logic [ID_W-1:0] m_arid,
  output logic [31:0]     m_araddr,
  output logic [7:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [ID_W-1:0] m_rid,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rlast,
  input  logic            m_rvalid,
  output logic            m_rready,
  output logic [ID_W-1:0] m_awid,
  output logic [31:0]     m_awaddr,
  output logic [7:0]      m_awlen,
  output logic [2:0]      m_awsize,
  output logic [1:0]      m_awburst,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [31:0]     m_wdata,
  output logic [3:0]      m_wstrb,
  output logic            m_wlast,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  logic [ID_W-1:0] m_bid,
  input  logic [1:0]      m_bresp,
  input  logic            m_bvalid,
  output logic            m_bready,
  output logic [1:0]      rd_state_o,
  output logic [1:0]      wr_state_o
);

  // Handshakes: a transfer happens on the rising edge where valid & ready are both high;
  // a valid, once raised, holds its payload stable until that edge.

  rd_state_t   rd_state, rd_nx;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        rd_guard;
  logic        rd_start;
  logic        rd_beat;
  logic        rd_done;

  assign m_arid        = ID_W'(RD_ID);
  assign m_araddr      = araddr;
  assign m_arlen       = arlen;
  assign m_arsize      = AXI_SIZE_4B;
  assign m_arburst     = AXI_BURST_INCR;
  assign m_arvalid     = (rd_state == R_ADDR);
  assign m_rready      = (rd_state == R_DATA) & rready_i;
  assign rd_beat       = (rd_state == R_DATA) & m_rvalid & rready_i;
  assign rd_done       = rd_beat & m_rlast;
  assign rdata_o       = m_rdata;
  assign rdata_valid_o = rd_beat;
  assign rd_state_o    = rd_state;

  // rd_guard blocks re-issue in the cycle after rlast while upstream drops ren_i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      araddr   <= '0;
      arlen    <= '0;
      rd_guard <= 1'b0;
    end else begin
      rd_state <= rd_nx;
      rd_guard <= rd_done;
      if (rd_start) begin
        araddr <= raddr_i;
        arlen  <= rlen_i;
      end
    end
  end

  always_comb begin
    rd_nx    = rd_state;
    rd_start = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (ce_i && ren_i && !rd_guard) begin
          rd_start = 1'b1;
          rd_nx    = R_ADDR;
        end
      end
      R_ADDR:  if (m_arready) rd_nx = R_DATA;
      R_DATA:  if (rd_done)   rd_nx = R_IDLE;
      default: rd_nx = R_IDLE;
    endcase
  end

  cache_axi_master_wr #(.ID_W(ID_W), .WR_ID(WR_ID)) u_wr (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .wen_i        (wen_i),
    .waddr_i      (waddr_i),
    .wlen_i       (wlen_i),
    .wsel_i       (wsel_i),
    .wdata_i      (wdata_i),
    .wdata_resp_o (wdata_resp_o),
    .m_awid       (m_awid),
    .m_awaddr     (m_awaddr),
    .m_awlen      (m_awlen),
    .m_awsize     (m_awsize),
    .m_awburst    (m_awburst),
    .m_awvalid    (m_awvalid),
    .m_awready    (m_awready),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_wlast      (m_wlast),
    .m_wvalid     (m_wvalid),
    .m_wready     (m_wready),
    .m_bvalid     (m_bvalid),
    .m_bready     (m_bready),
    .wr_state_o   (wr_state_o)
  );

  logic unused_in;

`ifdef AXI_ERR_CAPTURE_EN
  assign unused_in = ^{m_rid, m_bid};

  // First bad response wins; later errors leave the recorded address untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (!err_o) begin
      if (rd_beat && resp_err(m_rresp)) begin
        err_o      <= 1'b1;
        err_addr_o <= araddr;
      end else if (m_bvalid && m_bready && resp_err(m_bresp)) begin
        err_o      <= 1'b1;
        err_addr_o <= m_awaddr;
      end
    end
  end
`else
  assign unused_in = ^{m_rid, m_bid, m_rresp, m_bresp};
`endif

endmodule

// File: tb/tb_cache_axi_master.sv
// Randomized bench for cache_axi_master: AXI slave responders plus an upstream model per path.
// Define AXI_ERR_CAPTURE_EN for both RTL and bench to cover the error-capture outputs.
module tb_cache_axi_master;
  import axi_pkg::*;

  localparam int ID_W = 4;

  logic            clk, rst, ce_i;
  logic            ren_i, rready_i, rdata_valid_o;
  logic [31:0]     raddr_i, rdata_o;
  logic [7:0]      rlen_i;
  logic            wen_i, wdata_resp_o;
  logic [31:0]     waddr_i, wdata_i;
  logic [7:0]      wlen_i;
  logic [3:0]      wsel_i;
  logic [ID_W-1:0] m_arid, m_rid, m_awid, m_bid;
  logic [31:0]     m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [7:0]      m_arlen, m_awlen;
  logic [2:0]      m_arsize, m_awsize;
  logic [1:0]      m_arburst, m_awburst, m_rresp, m_bresp;
  logic            m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic            m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic [3:0]      m_wstrb;
  logic            m_bvalid, m_bready;
  logic [1:0]      rd_state_o, wr_state_o;
`ifdef AXI_ERR_CAPTURE_EN
  logic            err_o;
  logic [31:0]     err_addr_o;
`endif

  int errors = 0;
  int checks = 0;

  cache_axi_master #(.ID_W(ID_W), .RD_ID(0), .WR_ID(1)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i),
    .ren_i(ren_i), .raddr_i(raddr_i), .rlen_i(rlen_i), .rready_i(rready_i),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .wen_i(wen_i), .waddr_i(waddr_i), .wlen_i(wlen_i), .wsel_i(wsel_i),
    .wdata_i(wdata_i), .wdata_resp_o(wdata_resp_o),
`ifdef AXI_ERR_CAPTURE_EN
    .err_o(err_o), .err_addr_o(err_addr_o),
`endif
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .rd_state_o(rd_state_o), .wr_state_o(wr_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Read driver + slave responder; reference: one AR carrying (addr,len), then len+1
  // upstream pulses delivering the slave data in order, and no further AR afterwards.
  task automatic rd_txn(input logic [31:0] addr, input logic [7:0] len,
                        input logic [31:0] base, input int stall, input logic [1:0] resp);
    logic [31:0] beats[$];
    int phase = 0, beat = 0, cyc = 0, hold = 0, extra_ar = 0;
    for (int i = 0; i <= int'(len); i++)
      beats.push_back(base != 0 ? base + 32'(i) : $urandom());
    @(negedge clk);
    ce_i = 1'b1; ren_i = 1'b1; raddr_i = addr; rlen_i = len;
    while (phase < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      m_arready = (phase == 0) && (cyc > stall) && ($urandom_range(0, 1) == 1);
      m_rvalid  = (phase == 1) && ($urandom_range(0, 2) != 0);
      m_rdata   = (phase == 1) ? beats[beat] : $urandom();
      m_rlast   = (phase == 1) && (beat == int'(len));
      m_rresp   = resp;
      rready_i  = ($urandom_range(0, 3) != 0);
      if (phase == 2 && hold >= 1) ren_i = 1'b0;
      #1;
      case (phase)
        0: begin
          if (rdata_valid_o) check("rd_early_beat", rdata_valid_o, 1'b0);
          if (m_arvalid && m_arready) begin
            check("ar_addr", m_araddr, addr);
            check("ar_len", m_arlen, len);
            check("ar_size", m_arsize, 3'b010);
            check("ar_burst", m_arburst, 2'b01);
            check("ar_id", m_arid, 0);
            phase = 1;
          end
        end
        1: begin
          if (m_arvalid) extra_ar++;
          check("rd_valid", rdata_valid_o, m_rvalid & rready_i);
          if (m_rvalid && rready_i) begin
            check("rd_data", rdata_o, beats[beat]);
            beat++;
            if (beat > int'(len)) phase = 2;
          end
        end
        default: begin
          if (m_arvalid) extra_ar++;
          hold++;
          if (hold >= 4) phase = 3;
        end
      endcase
    end
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; ren_i = 1'b0;
    if (phase < 3) check("rd_timeout", 1'b1, 1'b0);
    check("rd_extra_ar", extra_ar, 0);
    check("rd_state_idle", rd_state_o, R_IDLE);
  endtask

  // Write driver + slave responder; reference: one AW, len+1 W beats carrying the upstream
  // words, wlast only on the final beat, len pulses on data and the final pulse with B.
  task automatic wr_txn(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] strb,
                        input int stall, input int bdelay, input logic [1:0] resp);
    logic [31:0] words[$];
    int phase = 0, beat = 0, cyc = 0, hold = 0, bwait = 0;
    int extra_aw = 0, early_w = 0, pulses = 0;
    for (int i = 0; i <= int'(len); i++) words.push_back($urandom());
    @(negedge clk);
    ce_i = 1'b1; wen_i = 1'b1; waddr_i = addr; wlen_i = len; wsel_i = strb;
    wdata_i = words[0];
    while (phase < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      m_awready = (phase == 0) && (cyc > stall) && ($urandom_range(0, 1) == 1);
      m_wready  = (phase == 1) && ($urandom_range(0, 1) == 1);
      m_bvalid  = (phase == 2) && (bwait >= bdelay);
      m_bresp   = resp;
      wdata_i   = (beat <= int'(len)) ? words[beat] : $urandom();
      if (phase == 3 && hold >= 1) wen_i = 1'b0;
      #1;
      if (wdata_resp_o) pulses++;
      case (phase)
        0: begin
          if (m_wvalid) early_w++;
          if (m_awvalid && m_awready) begin
            check("aw_addr", m_awaddr, addr);
            check("aw_len", m_awlen, len);
            check("aw_size", m_awsize, 3'b010);
            check("aw_burst", m_awburst, 2'b01);
            check("aw_id", m_awid, 1);
            phase = 1;
          end
        end
        1: begin
          check("w_valid", m_wvalid, 1'b1);
          if (m_wready) begin
            check("w_data", m_wdata, words[beat]);
            check("w_strb", m_wstrb, strb);
            check("w_last", m_wlast, beat == int'(len));
            check("w_pulse", wdata_resp_o, beat != int'(len));
            beat++;
            if (beat > int'(len)) phase = 2;
          end
        end
        2: begin
          if (m_wvalid) early_w++;
          if (m_bvalid) begin
            check("b_ready", m_bready, 1'b1);
            check("b_pulse", wdata_resp_o, 1'b1);
            phase = 3;
          end else begin
            bwait++;
            if (wdata_resp_o) check("b_early_pulse", wdata_resp_o, 1'b0);
          end
        end
        default: begin
          if (m_awvalid) extra_aw++;
          hold++;
          if (hold >= 4) phase = 4;
        end
      endcase
    end
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; wen_i = 1'b0;
    if (phase < 4) check("wr_timeout", 1'b1, 1'b0);
    check("wr_pulses", pulses, int'(len) + 1);
    check("wr_extra_aw", extra_aw, 0);
    check("wr_w_outside_burst", early_w, 0);
    check("wr_state_idle", wr_state_o, W_IDLE);
  endtask

  task automatic reset_mid_write();
    int n = 0;
    @(negedge clk);
    ce_i = 1'b1; wen_i = 1'b1; waddr_i = 32'h0000_3000; wlen_i = 8'd3; wsel_i = 4'hF;
    m_awready = 1'b1; m_wready = 1'b0;
    do begin
      @(negedge clk); #1; n++;
    end while (!m_wvalid && n < 20);
    if (!m_wvalid) check("rst_wvalid_seen", m_wvalid, 1'b1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("rst_awvalid", m_awvalid, 1'b0);
    check("rst_wvalid", m_wvalid, 1'b0);
    check("rst_bready", m_bready, 1'b0);
    check("rst_pulse", wdata_resp_o, 1'b0);
    check("rst_awaddr", m_awaddr, 32'h0);
    check("rst_wr_state", wr_state_o, W_IDLE);
    @(negedge clk);
    wen_i = 1'b0; m_awready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; ce_i = 1'b0;
    ren_i = 1'b0; raddr_i = '0; rlen_i = '0; rready_i = 1'b0;
    wen_i = 1'b0; waddr_i = '0; wlen_i = '0; wsel_i = '0; wdata_i = '0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = OKAY; m_rlast = 1'b0; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bid = 4'd1; m_bresp = OKAY; m_bvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_arvalid0", m_arvalid, 1'b0);
    check("rst_rready0", m_rready, 1'b0);
    check("rst_awvalid0", m_awvalid, 1'b0);
    check("rst_wvalid0", m_wvalid, 1'b0);
    check("rst_bready0", m_bready, 1'b0);
    check("rst_araddr0", m_araddr, 32'h0);
    check("rst_awlen0", m_awlen, 8'h0);
    check("rst_rd_state0", rd_state_o, R_IDLE);
    check("rst_wr_state0", wr_state_o, W_IDLE);
`ifdef AXI_ERR_CAPTURE_EN
    check("rst_err0", err_o, 1'b0);
`endif
    rst = 1'b1;

    rd_txn(32'h1C00_0020, 8'd7, 32'h0000_00A0, 2, OKAY);
    rd_txn(32'hBFAF_8000, 8'd0, 32'h1234_5678, 0, OKAY);
    wr_txn(32'h0000_1000, 8'd7, 4'hF, 0, 3, OKAY);
    wr_txn(32'h0000_1800, 8'd0, 4'b0011, 1, 2, OKAY);

    fork
      rd_txn(32'h2000_0040, 8'd7, 32'h0, 5, OKAY);
      wr_txn(32'h3000_0080, 8'd7, 4'hC, 5, 1, OKAY);
    join

    for (int t = 0; t < 6; t++) begin
      logic [7:0] rl, wl;
      rl = ($urandom_range(0, 1) == 1) ? 8'd7 : 8'd0;
      wl = 8'($urandom_range(0, 15));
      fork
        rd_txn({$urandom(), 2'b00} & 32'hFFFF_FFFC, rl, 32'h0, $urandom_range(0, 5), OKAY);
        wr_txn({$urandom(), 2'b00} & 32'hFFFF_FFFC, wl, 4'($urandom_range(1, 15)),
               $urandom_range(0, 5), $urandom_range(0, 4), OKAY);
      join
    end

`ifdef AXI_ERR_CAPTURE_EN
    wr_txn(32'h0000_2000, 8'd0, 4'hF, 0, 1, SLVERR);
    check("err_set", err_o, 1'b1);
    check("err_addr", err_addr_o, 32'h0000_2000);
    rd_txn(32'h0000_4000, 8'd7, 32'h0, 0, DECERR);
    wr_txn(32'h0000_5000, 8'd3, 4'hF, 0, 0, OKAY);
    check("err_sticky", err_o, 1'b1);
    check("err_addr_sticky", err_addr_o, 32'h0000_2000);
`endif

    reset_mid_write();
    rd_txn(32'h0000_0100, 8'd0, 32'h0, 0, OKAY);
    wr_txn(32'h0000_0200, 8'd1, 4'hF, 0, 0, OKAY);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_axi_master.md
Name: cache_axi_master

Overview:
- Downstream neighbour of the cache/AXI arbiter. Converts its simplified per-word bus into full AXI4 master channels: AR, R, AW, W and B.
- Read and write paths are independent FSMs and may be active at the same time.
- Sits between the cache arbiter and the SoC AXI crossbar.

Parameters:
- ID_W, 4, width of AXI ID fields.
- RD_ID, 0, constant ARID.
- WR_ID, 1, constant AWID/WID.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset (clear when 0).
- ce_i  in  1  enable; when 0, new requests are ignored.
- ren_i  in  1  read request, held high until the transfer finishes.
- raddr_i  in  32  read address; sampled at AR issue.
- rlen_i  in  8  burst length minus 1 (0 or 7).
- rready_i  in  1  upstream ready for read beats.
- rdata_o  out  32  read beat data.
- rdata_valid_o  out  1  one read beat delivered.
- wen_i  in  1  write request, held high until the transfer finishes.
- waddr_i  in  32  write address; sampled at AW issue.
- wlen_i  in  8  burst length minus 1.
- wsel_i  in  4  byte strobe.
- wdata_i  in  32  current write word.
- wdata_resp_o  out  1  per-beat advance/completion pulse.
- m_arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/32/8/3/2/1.
- m_arready  in  1.
- m_rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1.
- m_rready  out  1.
- m_awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/32/8/3/2/1.
- m_awready  in  1.
- m_wdata/wstrb/wlast/wvalid  out  32/4/1/1.
- m_wready  in  1.
- m_bid/bresp/bvalid  in  ID_W/2/1.
- m_bready  out  1.

Behaviour:
- Reset (rst=0, asynchronous): both FSMs go to IDLE. All valid/ready/pulse outputs are 0; addresses and lengths are 0. Reset mid-burst abandons the burst; no recovery is attempted.
- Constant fields: arsize=awsize=3'b010; arburst=awburst=2'b01 (INCR).
- Read FSM, states R_IDLE, R_ADDR, R_DATA:
  - R_IDLE -> R_ADDR when ce_i & ren_i. On that edge, register araddr=raddr_i, arlen=rlen_i; m_arvalid goes high.
  - R_ADDR: hold m_arvalid until m_arready; then go to R_DATA with m_arvalid=0. The AR payload stays stable while m_arvalid is high.
  - R_DATA: m_rready=rready_i; rdata_o=m_rdata (combinational). rdata_valid_o = m_rvalid & rready_i.
  - On a beat with m_rlast, return to R_IDLE.
  - R_IDLE ignores ren_i for the one cycle immediately after rlast (a registered guard bit). This prevents re-issue while upstream drops ren_i.
- Write FSM, states W_IDLE, W_ADDR, W_DATA, W_RESP:
  - W_IDLE -> W_ADDR when ce_i & wen_i. On that edge, latch awaddr, awlen, wstrb=wsel_i, and clear beat_cnt.
  - W_ADDR -> W_DATA on m_awready. W never precedes AW.
  - W_DATA: m_wvalid=1; m_wdata=wdata_i and m_wstrb=latched strobe (combinational); m_wlast=(beat_cnt==awlen).
  - Each non-last handshake (m_wvalid & m_wready) pulses wdata_resp_o for 1 cycle and increments beat_cnt (8-bit).
  - Last handshake -> W_RESP with no pulse.
  - W_RESP: m_bready=1. On m_bvalid, pulse wdata_resp_o once, then go to W_IDLE with the same one-cycle guard as the read path.
  - Net effect: upstream sees exactly awlen+1 pulses, the final one only after B.
- Simultaneous read and write requests: both proceed independently; there is no arbitration.
- rresp/bresp are ignored unless the optional feature is enabled.
- beat_cnt cannot wrap: the maximum length is 255 and the counter clears at each AW.

Optional Feature:
- Macro AXI_ERR_CAPTURE_EN.
- Defined: adds outputs err_o (1) and err_addr_o (32).
  - The first R beat or B with resp!=OKAY sets sticky err_o=1 and records the burst's latched address.
  - Cleared only by reset.
- Undefined: these ports and their logic are absent; responses are ignored.

Decomposition:
- Shared package axi_pkg holds:
  - AXI_BURST_INCR, AXI_SIZE_4B, and the resp codes OKAY/EXOKAY/SLVERR/DECERR.
  - The read and write state enum typedefs.
- Natural sub-module: cache_axi_master_wr, containing the write FSM, beat counter and B wait. The read path stays inline.

Test Plan:
- Burst read: ren=1, raddr=0x1C000020, rlen=7; arready after 2 cycles; 8 R beats 0xA0..0xA7 with rlast on the last -> one AR with araddr=0x1C000020, arlen=7; 8 rdata_valid_o pulses carrying the data in order; FSM back in R_IDLE and no second AR.
- Uncached single read: rlen=0, raddr=0xBFAF8000, rdata=0x12345678 -> arlen=0; one rdata_valid_o pulse with 0x12345678.
- Burst write: waddr=0x00001000, wlen=7, wready toggling, bvalid 3 cycles after wlast -> 8 W beats; wlast only on the 8th; 7 pulses during data, 8th pulse the cycle bvalid is seen.
- Uncached write: wsel=4'b0011, wlen=0 -> wstrb=0011, wlast=1 on the single beat; one pulse after B.
- Concurrent read and write with arready/awready stalls of 5 cycles, plus reset asserted mid-write -> channels independent; on reset, all valids drop asynchronously and the FSM is in W_IDLE.
- With AXI_ERR_CAPTURE_EN: bresp=SLVERR on write to 0x2000 -> err_o=1, err_addr_o=0x2000, sticky across later OKAY transfers.
